// File: rtl/sar_adc_pkg.sv
// Shared types and default sizing for the R2R-ladder SAR ADC.
package sar_adc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SET_BIT,
        SETTLE,
        COMPARE,
        DONE
    } state_e;

    localparam int DEF_WIDTH         = 8;
    localparam int DEF_SETTLE_CYCLES = 1000;
    localparam int DEF_AVG_LOG2      = 2;

endpackage

// File: rtl/synchronizer_2ff.sv
// Two-flop synchronizer for asynchronous inputs, async active-high reset.
module synchronizer_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/sar_adc_r2r.sv
// SAR ADC driving an R2R ladder and reading back an external comparator.
// Define SAR_ADC_AVERAGE_EN to average 2^AVG_LOG2 back-to-back conversions per result.
module sar_adc_r2r
    import sar_adc_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int AVG_LOG2      = DEF_AVG_LOG2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             comparator_in,
    output logic [WIDTH-1:0] R2R_out,
    output logic [WIDTH-1:0] data_out,
    output logic             ready,
    output logic             busy
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] r2r_q, r2r_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [IW-1:0]    bit_idx_q, bit_idx_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             comp_sync;
    logic [WIDTH-1:0] conv_res;

    synchronizer_2ff #(.W(1)) u_comp_sync (
        .clk (clk),
        .rst (reset),
        .d_i (comparator_in),
        .q_o (comp_sync)
    );

    // Result of the bit-0 compare; lower bits are always clear at that point.
    assign conv_res = result_q | WIDTH'(comp_sync);

`ifdef SAR_ADC_AVERAGE_EN
    localparam int AW = WIDTH + AVG_LOG2;
    localparam int NW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    logic [AW-1:0] acc_q, acc_d, acc_sum;
    logic [NW-1:0] conv_q, conv_d;
    logic          last_conv;

    assign acc_sum   = acc_q + AW'(conv_res);
    assign last_conv = (conv_q == NW'((1 << AVG_LOG2) - 1));
`endif

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        r2r_d     = r2r_q;
        dout_d    = dout_q;
        bit_idx_d = bit_idx_q;
        cnt_d     = cnt_q;
`ifdef SAR_ADC_AVERAGE_EN
        acc_d     = acc_q;
        conv_d    = conv_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    result_d  = '0;
                    bit_idx_d = IW'(WIDTH - 1);
                    state_d   = SET_BIT;
`ifdef SAR_ADC_AVERAGE_EN
                    acc_d     = '0;
                    conv_d    = '0;
`endif
                end
            end
            SET_BIT: begin
                r2r_d   = result_q | (WIDTH'(1) << bit_idx_q);
                cnt_d   = '0;
                state_d = SETTLE;
            end
            SETTLE: begin
                if (cnt_q == CW'(SETTLE_CYCLES - 1)) state_d = COMPARE;
                else                                 cnt_d   = cnt_q + 1'b1;
            end
            COMPARE: begin
                result_d[bit_idx_q] = comp_sync;
                if (bit_idx_q == '0) begin
                    // Outputs are loaded on entry so they are valid while ready is high.
`ifdef SAR_ADC_AVERAGE_EN
                    acc_d = acc_sum;
                    if (last_conv) begin
                        dout_d  = WIDTH'(acc_sum >> AVG_LOG2);
                        r2r_d   = WIDTH'(acc_sum >> AVG_LOG2);
                        state_d = DONE;
                    end else begin
                        conv_d    = conv_q + 1'b1;
                        result_d  = '0;
                        bit_idx_d = IW'(WIDTH - 1);
                        state_d   = SET_BIT;
                    end
`else
                    dout_d  = conv_res;
                    r2r_d   = conv_res;
                    state_d = DONE;
`endif
                end else begin
                    bit_idx_d = bit_idx_q - 1'b1;
                    state_d   = SET_BIT;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            result_q  <= '0;
            r2r_q     <= '0;
            dout_q    <= '0;
            bit_idx_q <= IW'(WIDTH - 1);
            cnt_q     <= '0;
`ifdef SAR_ADC_AVERAGE_EN
            acc_q     <= '0;
            conv_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            r2r_q     <= r2r_d;
            dout_q    <= dout_d;
            bit_idx_q <= bit_idx_d;
            cnt_q     <= cnt_d;
`ifdef SAR_ADC_AVERAGE_EN
            acc_q     <= acc_d;
            conv_q    <= conv_d;
`endif
        end
    end

    assign R2R_out  = r2r_q;
    assign data_out = dout_q;
    assign ready    = (state_q == DONE);
    assign busy     = (state_q != IDLE);

endmodule
